// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Turns a byte-length-tagged message, delivered as 64-bit beats, into
// SHA-256 padded 512-bit chunks for the compression stage.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   msg_start      pulse to begin a message (taken only when idle)
//   msg_len        message length in bytes, sampled with msg_start
//   busy           high from message acceptance until the last chunk handshake
//   in_valid       beat valid
//   in_data        8 message bytes, first byte in [63:56]
//   in_ready       padder accepts a beat this cycle
//   chunk_valid    chunk_data valid
//   chunk_ready    downstream accepts the chunk
//   chunk_data     word j in [32j+31:32j], big-endian bytes within a word
//   chunk_first    chunk is the first of its message
//   chunk_last     chunk is the final chunk of its message
module sha256_msg_padder #(
    parameter int unsigned CHUNKSIZE = 512,
    parameter int unsigned LEN_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 msg_start,
    input  logic [LEN_W-1:0]     msg_len,
    output logic                 busy,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    output logic                 in_ready,
    output logic                 chunk_valid,
    input  logic                 chunk_ready,
    output logic [CHUNKSIZE-1:0] chunk_data,
    output logic                 chunk_first,
    output logic                 chunk_last
);

    localparam int unsigned WORDS      = 16;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BEAT_BYTES = 8;
    localparam int unsigned LBITS_W    = 64;
    localparam int unsigned BYTES_W    = 7;    // byte count within a chunk, 0..64
    localparam int unsigned MAX_LEN_IN = 55;   // last byte index that still leaves room for the length

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [LEN_W-1:0]       bytes_left_q;
    logic [LBITS_W-1:0]     len_bits_q;
    logic [2:0]             beat_ptr_q;
    logic                   first_q;
    logic                   last_q;
    logic                   pad_pending_q;
    logic                   go_tail_q;
    logic [WORD_W-1:0]      buf_q [WORDS];

    logic                   in_ready_d;
    logic                   chunk_valid_d;
    logic                   busy_d;

    logic                   beat_fire;
    logic                   take_full;
    logic                   last_beat;
    logic [3:0]             take;
    logic [BYTES_W-1:0]     chunk_bytes;
    logic                   fits_len;
    logic [2:0]             next_ptr;
    logic [63:0]            beat_masked;

    // Beat bookkeeping: how many bytes this beat contributes and where the chunk ends up.
    always_comb begin
        beat_fire   = (state_q == LOAD) && in_valid;
        take_full   = (bytes_left_q >= LEN_W'(BEAT_BYTES));
        last_beat   = (bytes_left_q <= LEN_W'(BEAT_BYTES));
        take        = take_full ? 4'd8 : bytes_left_q[3:0];
        chunk_bytes = {1'b0, beat_ptr_q, 3'b000} + {3'b000, take};
        fits_len    = (chunk_bytes <= BYTES_W'(MAX_LEN_IN));
        next_ptr    = beat_ptr_q + 3'd1;
    end

    // Keep valid bytes, place the 0x80 marker right after them, zero the rest.
    // With a full beat take==8, so the marker never lands inside the beat.
    always_comb begin
        beat_masked = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < take) begin
                beat_masked[63-8*i -: 8] = in_data[63-8*i -: 8];
            end else if (4'(i) == take) begin
                beat_masked[63-8*i -: 8] = 8'h80;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (msg_start) begin
                    state_d = (msg_len == '0) ? TAIL : LOAD;
                end
            end
            LOAD: begin
                if (beat_fire && (last_beat || (beat_ptr_q == 3'd7))) begin
                    state_d = EMIT;
                end
            end
            TAIL: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (chunk_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else if (go_tail_q) begin
                        state_d = TAIL;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the handshake outputs come straight from flops.
    always_comb begin
        in_ready_d    = 1'b0;
        chunk_valid_d = 1'b0;
        busy_d        = 1'b0;
        case (state_d)
            LOAD: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            EMIT: begin
                chunk_valid_d = 1'b1;
                busy_d        = 1'b1;
            end
            TAIL: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready    <= 1'b0;
            chunk_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            in_ready    <= in_ready_d;
            chunk_valid <= chunk_valid_d;
            busy        <= busy_d;
        end
    end

    // Chunk buffer and message bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_left_q  <= '0;
            len_bits_q    <= '0;
            beat_ptr_q    <= '0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            pad_pending_q <= 1'b0;
            go_tail_q     <= 1'b0;
            for (int w = 0; w < WORDS; w++) begin
                buf_q[w] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (msg_start) begin
                        bytes_left_q  <= msg_len;
                        len_bits_q    <= LBITS_W'({msg_len, 3'b000});
                        beat_ptr_q    <= '0;
                        first_q       <= 1'b1;
                        last_q        <= 1'b0;
                        go_tail_q     <= 1'b0;
                        pad_pending_q <= (msg_len == '0);
                        for (int w = 0; w < WORDS; w++) begin
                            buf_q[w] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (beat_fire) begin
                        buf_q[{beat_ptr_q, 1'b0}] <= beat_masked[63:32];
                        buf_q[{beat_ptr_q, 1'b1}] <= beat_masked[31:0];
                        bytes_left_q <= bytes_left_q - LEN_W'(take);
                        beat_ptr_q   <= next_ptr;
                        if (last_beat) begin
                            // A full final beat pushes the marker into the next beat slot,
                            // or into the tail chunk when this chunk is now full.
                            if (take_full && (beat_ptr_q != 3'd7)) begin
                                buf_q[{next_ptr, 1'b0}] <= 32'h8000_0000;
                            end
                            pad_pending_q <= take_full && (beat_ptr_q == 3'd7);
                            if (fits_len) begin
                                buf_q[14] <= len_bits_q[63:32];
                                buf_q[15] <= len_bits_q[31:0];
                                last_q    <= 1'b1;
                            end else begin
                                go_tail_q <= 1'b1;
                            end
                        end
                    end
                end
                TAIL: begin
                    for (int w = 0; w < WORDS; w++) begin
                        buf_q[w] <= '0;
                    end
                    buf_q[0]      <= pad_pending_q ? 32'h8000_0000 : 32'h0;
                    buf_q[14]     <= len_bits_q[63:32];
                    buf_q[15]     <= len_bits_q[31:0];
                    last_q        <= 1'b1;
                    pad_pending_q <= 1'b0;
                    go_tail_q     <= 1'b0;
                end
                EMIT: begin
                    if (chunk_ready) begin
                        first_q <= 1'b0;
                        last_q  <= 1'b0;
                        for (int w = 0; w < WORDS; w++) begin
                            buf_q[w] <= '0;
                        end
                    end
                end
                default: begin
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the word buffer into the chunk bus.
    for (genvar j = 0; j < WORDS; j++) begin : g_word
        assign chunk_data[WORD_W*j +: WORD_W] = buf_q[j];
    end

    assign chunk_first = first_q;
    assign chunk_last  = last_q;

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the 64-round SHA-256 compression stage.
- Accepts a byte-length-tagged message as a stream of 64-bit memory beats and applies SHA-256 padding: 0x80 marker, zero fill, and a 64-bit big-endian bit length.
- Emits one 512-bit chunk at a time with a valid/ready handshake, in exactly the layout the compression stage's memorychunk input expects.
- chunk_first and chunk_last let downstream logic select the initial H constants and recognise the final digest.

Parameters:
- CHUNKSIZE, 512, chunk width in bits; fixed at 512, no other value supported.
- LEN_W, 32, width of the message byte-length input.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- msg_start  input  1  pulse: begin a message; accepted only in IDLE
- msg_len  input  LEN_W  message length in bytes; sampled with msg_start
- busy  output  1  high from msg_start acceptance until the last chunk handshake
- in_valid  input  1  data beat valid
- in_data  input  64  8 message bytes; first byte in [63:56]
- in_ready  output  1  padder accepts a beat this cycle
- chunk_valid  output  1  chunk_data valid
- chunk_ready  input  1  downstream accepts the chunk
- chunk_data  output  CHUNKSIZE  word j (0..15) in bits [32j+31:32j], big-endian byte order within each word
- chunk_first  output  1  chunk is the first of its message
- chunk_last  output  1  chunk is the final chunk of its message

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: all outputs 0, chunk buffer cleared, state IDLE. Reset asserted mid-message aborts immediately: partial chunk discarded, no further output.
- States: IDLE, LOAD, EMIT, TAIL.
- IDLE:
  - in_ready=0, busy=0.
  - msg_start=1 latches msg_len into bytes_left and len_bits = {msg_len,3'b0} zero-extended to 64 bits.
  - Clears buffer and beat_ptr, sets first flag, goes to LOAD.
  - If msg_len==0, goes to TAIL instead, with pad_pending=1.
  - msg_start outside IDLE is ignored.
- LOAD:
  - in_ready=1. An accepted beat is written to buffer words 2*beat_ptr (in_data[63:32]) and 2*beat_ptr+1 (in_data[31:0]).
  - Bytes beyond bytes_left in the final beat are forced to 0. If bytes_left<8, byte position bytes_left gets 0x80.
  - If bytes_left==8 exactly, the 0x80 goes into the next beat slot: pad_pending=1.
  - bytes_left -= min(8, bytes_left). beat_ptr increments and wraps at 8.
- End of data (last beat accepted), with total bytes in this chunk r = msg_len mod 64 (r=64 if the chunk is full):
  - r<=55: write 0x80 (if pending) and len_bits into words 14/15 (word 14 = high 32 bits), set last flag, go to EMIT.
  - 56<=r<=63: 0x80 is already placed inside this chunk (pad_pending cleared); go to EMIT with last=0, then TAIL.
  - r==64: pad_pending=1; go to EMIT with last=0, then TAIL.
- Buffer full (beat_ptr wraps) with data remaining: go to EMIT with last=0, then back to LOAD.
- TAIL:
  - One cycle; in_ready=0.
  - Buffer = zeros, with word0=0x80000000 if pad_pending, and words 14/15 = len_bits.
  - Sets last flag, goes to EMIT.
- EMIT:
  - chunk_valid=1; chunk_data, chunk_first and chunk_last held stable until chunk_ready.
  - On the handshake:
    - first flag clears.
    - The buffer clears.
    - Next state is IDLE if last (busy drops the same edge), otherwise LOAD or TAIL as recorded.
  - in_ready=0 throughout EMIT.
- Latency: chunk_valid rises the cycle after the beat that completes the chunk. The TAIL chunk is valid 1 cycle after the preceding handshake.
- Throughput: one chunk in flight; a full data chunk takes 8 beat cycles + 1 handshake cycle minimum.
- Arithmetic: length is modulo 2^LEN_W bytes; the upper 64-LEN_W-3 bits of len_bits are zero.
- Simultaneous events: msg_start during EMIT of the previous message's last chunk is ignored (not IDLE yet). Beats presented while in_ready=0 are not consumed.

Test Plan:
- "abc": msg_len=3, one beat 0x6162630000000000 -> single chunk, word0=0x61626380, words1-14=0, word15=0x00000018, first=last=1. Feeding it to compression and adding H gives digest ba7816bf...f20015ad.
- Empty message: msg_len=0, no beats -> one chunk, word0=0x80000000, word15=0, first=last=1; digest e3b0c442...7852b855.
- msg_len=56 (7 beats of 0x41 bytes) -> chunk 1: words0-13=0x41414141, word14=0x80000000, word15=0, last=0. Chunk 2: all zero except word15=0x000001C0, last=1.
- msg_len=64 -> chunk 1 is all data, last=0. Chunk 2: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: hold chunk_ready=0 for 10 cycles during EMIT -> chunk_data stable, in_ready=0, no beat consumed. Garbage bytes beyond msg_len=13 in the final beat are masked to 0.
- Reset asserted after 3 beats of a 100-byte message -> next cycle outputs 0, busy=0. A following "abc" message produces the correct single chunk.
